uart_baud_nco: RTL

//  Parametrised fractional baud-rate generator; successor to the fixed-table HS generator.

---
 rtl/uart_baud_nco_pkg.sv | 33 +++
 rtl/uart_baud_phase_acc.sv | 32 +++
 rtl/uart_baud_nco.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_baud_nco_pkg.sv
// rtl/uart_baud_nco_pkg.sv - default geometry, standard-baud increments and phase-action type for the baud NCO
package uart_baud_nco_pkg;

   localparam int UART_ACC_W_DEF = 16;
   localparam int UART_OVS_DEF   = 16;

   // Increments for 100 MHz, ACC_W=16, OVS=16: round(baud*OVS*2^ACC_W/f_clk)
   localparam int UART_INC_9600   = 101;
   localparam int UART_INC_19200  = 201;
   localparam int UART_INC_38400  = 403;
   localparam int UART_INC_57600  = 604;
   localparam int UART_INC_115200 = 1208;
   localparam int UART_INC_230400 = 2416;
   localparam int UART_INC_460800 = 4832;
   localparam int UART_INC_921600 = 9664;

   typedef enum logic [1:0] {
      NCO_CLEAR,
      NCO_LOAD,
      NCO_SYNC,
      NCO_COUNT
   } nco_act_e;

   function automatic logic [31:0] uart_inc(input longint unsigned f_clk,
                                            input longint unsigned baud,
                                            input int unsigned     ovs,
                                            input int unsigned     acc_w);
      longint unsigned num;
      num = baud * longint'(ovs) * (64'd1 << acc_w);
      return 32'((num + f_clk / 2) / f_clk);
   endfunction

endpackage

// File: rtl/uart_baud_phase_acc.sv
// rtl/uart_baud_phase_acc.sv - ACC_W-bit phase accumulator with synchronous clear and carry out
module uart_baud_phase_acc #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [ACC_W-1:0] inc,
   output logic             carry
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W:0]   sum;

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc};
      acc_d = clr ? '0 : sum[ACC_W-1:0];
   end

   // Carry is only meaningful on a counting cycle; a clearing cycle restarts the phase.
   assign carry = sum[ACC_W] & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/uart_baud_nco.sv
// rtl/uart_baud_nco.sv - fractional baud generator: oversample tick, baud tick and bit-rate clk_slw
// Optional mid-bit phase re-sync input exists only when UART_BAUD_SYNC_EN is defined.
module uart_baud_nco
   import uart_baud_nco_pkg::*;
#(
   parameter int ACC_W   = UART_ACC_W_DEF,
   parameter int OVS     = UART_OVS_DEF,
   parameter int INC_RST = UART_INC_9600
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [ACC_W-1:0]        inc_in,
   input  logic                    inc_ld,
`ifdef UART_BAUD_SYNC_EN
   input  logic                    sync,
`endif
   output logic                    ovs_tick,
   output logic                    baud_tick,
   output logic                    clk_slw,
   output logic [$clog2(OVS)-1:0]  ovs_cnt
);

   localparam int CNT_W = $clog2(OVS);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(OVS - 1);
   localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(OVS / 2);
   localparam logic [CNT_W-1:0] CNT_PRE_HALF = CNT_W'(OVS / 2 - 1);

   logic [ACC_W-1:0] inc_q, inc_d;
   logic [CNT_W-1:0] ovs_cnt_q, ovs_cnt_d;
   logic             ovs_tick_q, ovs_tick_d;
   logic             baud_tick_q, baud_tick_d;
   logic             clk_slw_q, clk_slw_d;
   logic             acc_carry;
   nco_act_e         act;

   always_comb begin
      act = NCO_COUNT;
      if (!en) begin
         act = NCO_CLEAR;
      end else if (inc_ld) begin
         act = NCO_LOAD;
      end
`ifdef UART_BAUD_SYNC_EN
      else if (sync) begin
         act = NCO_SYNC;
      end
`endif
   end

   uart_baud_phase_acc #(
      .ACC_W (ACC_W)
   ) u_phase_acc (
      .clk   (clk),
      .rst_n (rst),
      .clr   (act != NCO_COUNT),
      .inc   (inc_q),
      .carry (acc_carry)
   );

   always_comb begin
      // The increment register loads even while disabled so software can program before enabling.
      inc_d       = inc_ld ? inc_in : inc_q;
      ovs_cnt_d   = ovs_cnt_q;
      clk_slw_d   = clk_slw_q;
      ovs_tick_d  = 1'b0;
      baud_tick_d = 1'b0;
      unique case (act)
         NCO_CLEAR, NCO_LOAD: begin
            ovs_cnt_d = '0;
            clk_slw_d = 1'b0;
         end
         NCO_SYNC: begin
            ovs_cnt_d = CNT_HALF;
            clk_slw_d = 1'b0;
         end
         default: begin
            if (acc_carry) begin
               ovs_tick_d = 1'b1;
               ovs_cnt_d  = ovs_cnt_q + CNT_W'(1);
               if (ovs_cnt_q == CNT_LAST) begin
                  baud_tick_d = 1'b1;
                  clk_slw_d   = 1'b1;
               end else if (ovs_cnt_q == CNT_PRE_HALF) begin
                  clk_slw_d = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inc_q       <= ACC_W'(INC_RST);
         ovs_cnt_q   <= '0;
         ovs_tick_q  <= 1'b0;
         baud_tick_q <= 1'b0;
         clk_slw_q   <= 1'b0;
      end else begin
         inc_q       <= inc_d;
         ovs_cnt_q   <= ovs_cnt_d;
         ovs_tick_q  <= ovs_tick_d;
         baud_tick_q <= baud_tick_d;
         clk_slw_q   <= clk_slw_d;
      end
   end

   assign ovs_tick  = ovs_tick_q;
   assign baud_tick = baud_tick_q;
   assign clk_slw   = clk_slw_q;
   assign ovs_cnt   = ovs_cnt_q;

endmodule
